display_scan_ctrl: RTL and testbench

//   Time-multiplexes N_DIGITS BCD digits through one shared combinational
//   bcd_to_7seg decoder and drives the common-cathode digit selects of the

---
 rtl/display_scan_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// Multiplexed display scanner: walks N_DIGITS BCD digits through one shared
// external 7-segment decoder. Each digit gets a blanking gap followed by a
// lit window. Digit values are double-buffered: a load only takes effect at
// a frame boundary, so a frame is never drawn from a mix of old and new data.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | scan disabled, all outputs 0, digit index held at 0
// BLANK   | all digits off, o_bcd presents active[idx] to the decoder
// SHOW    | digit idx selected, decoded segments registered every cycle
module display_scan_ctrl #(
  parameter int N_DIGITS     = 6,
  parameter int DIGIT_CYCLES = 4,
  parameter int BLANK_CYCLES = 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_en,
  input  logic                  i_load,
  input  logic [4*N_DIGITS-1:0] i_digits,
  input  logic [N_DIGITS-1:0]   i_blank,
  output logic [3:0]            o_bcd,
  input  logic [6:0]            i_seg,
  output logic [6:0]            o_seg,
  output logic [N_DIGITS-1:0]   o_dig_sel,
  output logic                  o_frame_start
);

  localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int MAX_CYC = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LOAD  = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_idx_nxt;
  logic                  w_frame_entry;
  logic                  w_cnt_done;
  logic                  w_last_digit;

  logic [4*N_DIGITS-1:0] r_active;
  logic [4*N_DIGITS-1:0] r_shadow;
  logic                  r_pending;
  logic [4*N_DIGITS-1:0] w_active_nxt;

  logic [3:0]            r_bcd;
  logic [6:0]            r_seg;
  logic [N_DIGITS-1:0]   r_dig_sel;
  logic                  r_frame_start;
  logic [3:0]            w_bcd_nxt;
  logic [6:0]            w_seg_nxt;
  logic [N_DIGITS-1:0]   w_sel_nxt;
  logic                  w_fs_nxt;

  assign w_cnt_done   = (r_cnt == '0);
  assign w_last_digit = (r_idx == LAST_IDX);

  // State register: FSM state, down-counter for the current phase, digit index
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state logic; a disable in any state returns to IDLE at digit 0
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_frame_entry = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        w_idx_nxt = '0;
        if (i_en) begin
          w_state_nxt   = ST_BLANK;
          w_cnt_nxt     = BLANK_LOAD;
          w_frame_entry = 1'b1;
        end
      end
      ST_BLANK: begin
        if (!i_en) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else if (w_cnt_done) begin
          w_state_nxt = ST_SHOW;
          w_cnt_nxt   = SHOW_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ST_SHOW: begin
        if (!i_en) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
        end else if (w_cnt_done) begin
          w_state_nxt = ST_BLANK;
          w_cnt_nxt   = BLANK_LOAD;
          if (w_last_digit) begin
            w_idx_nxt     = '0;
            w_frame_entry = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Output logic: next values of the registered outputs and the active buffer.
  // A load coinciding with the frame boundary bypasses the shadow register.
  always_comb begin
    w_active_nxt = r_active;
    if (w_frame_entry) begin
      if (i_load)
        w_active_nxt = i_digits;
      else if (r_pending)
        w_active_nxt = r_shadow;
    end
    w_bcd_nxt = '0;
    w_seg_nxt = '0;
    w_sel_nxt = '0;
    w_fs_nxt  = w_frame_entry;
    case (w_state_nxt)
      ST_BLANK: begin
        if (r_state != ST_BLANK)
          w_bcd_nxt = w_active_nxt[{w_idx_nxt, 2'b00} +: 4];
        else
          w_bcd_nxt = r_bcd;
      end
      ST_SHOW: begin
        w_bcd_nxt = r_bcd;
        w_sel_nxt = N_DIGITS'(1) << r_idx;
        w_seg_nxt = i_blank[r_idx] ? 7'd0 : i_seg;
      end
      default: begin
        w_bcd_nxt = '0;
      end
    endcase
  end

  // Double buffer: loads land in shadow and are promoted at the frame boundary
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_active  <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else begin
      r_active <= w_active_nxt;
      if (i_load)
        r_shadow <= i_digits;
      if (w_frame_entry)
        r_pending <= 1'b0;
      else if (i_load)
        r_pending <= 1'b1;
    end
  end

  // Output registers; async reset clears them immediately
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_bcd         <= '0;
      r_seg         <= '0;
      r_dig_sel     <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_bcd         <= w_bcd_nxt;
      r_seg         <= w_seg_nxt;
      r_dig_sel     <= w_sel_nxt;
      r_frame_start <= w_fs_nxt;
    end
  end

  assign o_bcd         = r_bcd;
  assign o_seg         = r_seg;
  assign o_dig_sel     = r_dig_sel;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: a behavioural 7-segment decoder closes the
// o_bcd -> i_seg loop, expected lit cycles are queued by the stimulus and
// popped by a monitor on every falling edge where a digit is selected.
module tb_display_scan_ctrl;

  localparam logic [6:0] S0 = 7'b1111110;
  localparam logic [6:0] S1 = 7'b0110000;
  localparam logic [6:0] S2 = 7'b1101101;
  localparam logic [6:0] S3 = 7'b1111001;
  localparam logic [6:0] S4 = 7'b0110011;
  localparam logic [6:0] S5 = 7'b1011011;
  localparam logic [6:0] S6 = 7'b1011111;
  localparam logic [6:0] S7 = 7'b1110000;
  localparam logic [6:0] S8 = 7'b1111111;
  localparam logic [6:0] S9 = 7'b1111011;

  // digit 5 in the top slice, digit 0 in the bottom slice
  localparam logic [41:0] F_123456 = {S1, S2, S3, S4, S5, S6};
  localparam logic [41:0] F_999999 = {S9, S9, S9, S9, S9, S9};
  localparam logic [41:0] F_087654_B5 = {7'b0, S8, S7, S6, S5, S4};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        load;
  logic [23:0] digits;
  logic [5:0]  blank;
  logic [3:0]  bcd;
  logic [6:0]  seg_dec;
  logic [6:0]  seg;
  logic [5:0]  sel;
  logic        fs;

  int          checks;
  int          errors;
  int          fs_epoch;
  int          cyc;
  int          last_fs;
  int          fs_ep;
  bit          fs_seen;
  logic [12:0] exp_q[$];
  logic [12:0] exp_e;

  display_scan_ctrl #(
    .N_DIGITS(6),
    .DIGIT_CYCLES(4),
    .BLANK_CYCLES(1)
  ) dut (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .i_en(en),
    .i_load(load),
    .i_digits(digits),
    .i_blank(blank),
    .o_bcd(bcd),
    .i_seg(seg_dec),
    .o_seg(seg),
    .o_dig_sel(sel),
    .o_frame_start(fs)
  );

  always #5 clk = ~clk;

  always_comb begin
    seg_dec = 7'b0;
    case (bcd)
      4'd0: seg_dec = S0;
      4'd1: seg_dec = S1;
      4'd2: seg_dec = S2;
      4'd3: seg_dec = S3;
      4'd4: seg_dec = S4;
      4'd5: seg_dec = S5;
      4'd6: seg_dec = S6;
      4'd7: seg_dec = S7;
      4'd8: seg_dec = S8;
      4'd9: seg_dec = S9;
      default: seg_dec = 7'b0;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [41:0] segs, input int n_lit);
    int cnt;
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      for (int r = 0; r < 4; r++) begin
        if (cnt < n_lit) begin
          exp_q.push_back({6'(1 << k), segs[7*k +: 7]});
          cnt++;
        end
      end
    end
  endtask

  // returns one ns after the edge that raised o_frame_start
  task automatic wait_fs();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (fs) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL frame_start wait: got timeout expected pulse at %0t", $time);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    fs_epoch = 0;
    cyc      = 0;
    last_fs  = 0;
    fs_ep    = 0;
    fs_seen  = 1'b0;
    rst_n    = 1'b0;
    en       = 1'b0;
    load     = 1'b0;
    digits   = '0;
    blank    = '0;

    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (rst_n) begin
          if (fs) begin
            if (fs_seen && fs_ep == fs_epoch)
              chk("frame_start period", cyc - last_fs, 30);
            fs_seen = 1'b1;
            fs_ep   = fs_epoch;
            last_fs = cyc;
          end
          if (sel != 6'b0) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected lit: got sel=%b seg=%b expected none at %0t", sel, seg, $time);
            end else begin
              exp_e = exp_q.pop_front();
              chk("lit digit {sel,seg}", {19'b0, sel, seg}, {19'b0, exp_e});
            end
          end else begin
            chk("seg off when unselected", {25'b0, seg}, 32'd0);
          end
        end
      end
    join_none

    #1;
    chk("reset o_seg", {25'b0, seg}, 32'd0);
    chk("reset o_dig_sel", {26'b0, sel}, 32'd0);
    chk("reset o_bcd", {28'b0, bcd}, 32'd0);
    chk("reset o_frame_start", {31'b0, fs}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle o_dig_sel", {26'b0, sel}, 32'd0);
    chk("idle o_frame_start", {31'b0, fs}, 32'd0);

    // load in IDLE, applied on start
    digits = 24'h123456;
    load   = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    push_frame(F_123456, 24);
    push_frame(F_123456, 24);
    en = 1'b1;
    @(posedge clk); #1;
    chk("start frame_start", {31'b0, fs}, 32'd1);
    chk("start blank sel", {26'b0, sel}, 32'd0);
    chk("start o_bcd digit0", {28'b0, bcd}, 32'd6);
    @(posedge clk); #1;
    chk("first show sel", {26'b0, sel}, 32'd1);
    chk("first show seg", {25'b0, seg}, {25'b0, S6});
    chk("frame_start single cycle", {31'b0, fs}, 32'd0);

    // mid-frame load: current frame unchanged, next frame all nines
    wait_fs();
    repeat (10) @(posedge clk);
    #1;
    digits = 24'h999999;
    load   = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    push_frame(F_999999, 24);

    // load on the boundary cycle goes straight into the new frame
    wait_fs();
    push_frame(F_087654_B5, 14);
    repeat (29) @(posedge clk);
    #1;
    digits = 24'h087654;
    blank  = 6'b100000;
    load   = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    chk("boundary load frame_start", {31'b0, fs}, 32'd1);
    chk("boundary load o_bcd", {28'b0, bcd}, 32'd4);

    // drop enable during SHOW of digit 3
    repeat (17) @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk); #1;
    chk("disable o_seg", {25'b0, seg}, 32'd0);
    chk("disable o_dig_sel", {26'b0, sel}, 32'd0);
    chk("disable o_bcd", {28'b0, bcd}, 32'd0);
    chk("disable o_frame_start", {31'b0, fs}, 32'd0);
    fs_epoch++;
    push_frame(F_087654_B5, 24);
    push_frame(F_087654_B5, 10);
    repeat (2) @(posedge clk);
    #1 en = 1'b1;
    wait_fs();
    chk("restart blank sel", {26'b0, sel}, 32'd0);
    chk("restart o_bcd digit0", {28'b0, bcd}, 32'd4);
    @(posedge clk); #1;
    chk("restart digit0 first", {26'b0, sel}, 32'd1);
    chk("restart digit0 seg", {25'b0, seg}, {25'b0, S4});

    // async reset during SHOW of digit 2
    wait_fs();
    repeat (12) @(posedge clk);
    #7;
    chk("pre-reset sel digit2", {26'b0, sel}, 32'd4);
    rst_n = 1'b0;
    #1;
    chk("async reset o_seg", {25'b0, seg}, 32'd0);
    chk("async reset o_dig_sel", {26'b0, sel}, 32'd0);
    chk("async reset o_bcd", {28'b0, bcd}, 32'd0);
    chk("async reset o_frame_start", {31'b0, fs}, 32'd0);
    fs_epoch++;
    en = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post-reset idle sel", {26'b0, sel}, 32'd0);
    chk("scoreboard drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
